// File: rtl/ps2_pkg.sv
// Shared Set-2 scan-code constants, receiver FSM encoding and frame check helper
// for the PS/2 keyboard path feeding the Pong paddles.
package ps2_pkg;

    localparam logic [7:0] PREFIX_BRK  = 8'hF0;
    localparam logic [7:0] PREFIX_EXT  = 8'hE0;

    localparam logic [7:0] DEF_CODE_W  = 8'h1D;
    localparam logic [7:0] DEF_CODE_S  = 8'h1B;
    localparam logic [7:0] DEF_CODE_O  = 8'h44;
    localparam logic [7:0] DEF_CODE_L  = 8'h4B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Odd parity over data+parity, and the stop bit must be high.
    function automatic logic frame_ok(input logic [7:0] data,
                                      input logic       par,
                                      input logic       stop);
        return (^data ^ par) & stop;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronizers, ps2_clk glitch filter, 11-bit frame
// FSM with mid-frame timeout. Emits byte/valid/err strobes on the stop-bit fall.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err
);

    localparam logic [3:0]  FLT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

    logic       r_clk_s1;
    logic       r_clk_s2;
    logic       r_dat_s1;
    logic       r_dat_s2;
    logic       r_clk_f;
    logic [3:0] r_flt_cnt;

    ps2_state_t  r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par;
    logic [15:0] r_idle_cnt;

    logic w_flip;
    logic w_fall;
    logic w_timeout;
    logic w_stop_fall;
    logic w_ok;

    // The filtered clock only moves after FILTER_LEN back-to-back disagreeing samples.
    assign w_flip    = (r_clk_s2 != r_clk_f) && (r_flt_cnt == FLT_LAST);
    assign w_fall    = w_flip && r_clk_f;
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_idle_cnt == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_clk_f   <= 1'b1;
            r_flt_cnt <= 4'd0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_dat;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 != r_clk_f) begin
                if (w_flip) begin
                    r_clk_f   <= r_clk_s2;
                    r_flt_cnt <= 4'd0;
                end else begin
                    r_flt_cnt <= r_flt_cnt + 4'd1;
                end
            end else begin
                r_flt_cnt <= 4'd0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_par      <= 1'b0;
            r_idle_cnt <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_idle_cnt <= 16'd0;
                    if (w_fall && !r_dat_s2) begin
                        r_state   <= DATA;
                        r_bit_cnt <= 3'd0;
                    end
                end
                default: begin
                    if (w_timeout) begin
                        r_state    <= IDLE;
                        r_idle_cnt <= 16'd0;
                    end else if (w_fall) begin
                        r_idle_cnt <= 16'd0;
                        case (r_state)
                            DATA: begin
                                // LSB arrives first, so shifting in at the top leaves bit 0 in place after 8 bits.
                                r_shift   <= {r_dat_s2, r_shift[7:1]};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                if (r_bit_cnt == 3'd7) begin
                                    r_state <= PARITY;
                                end
                            end
                            PARITY: begin
                                r_par   <= r_dat_s2;
                                r_state <= STOP;
                            end
                            default: begin
                                r_state <= IDLE;
                            end
                        endcase
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign w_stop_fall  = (r_state == STOP) && w_fall;
    assign w_ok         = frame_ok(r_shift, r_par, r_dat_s2);
    assign o_byte       = r_shift;
    assign o_byte_valid = w_stop_fall && w_ok;
    assign o_err        = (w_stop_fall && !w_ok) || w_timeout;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 decoder producing held-key levels for the W/S and O/L paddles;
// tracks the F0 (break) and E0 (extended) prefixes across received bytes.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int         FILTER_LEN  = 4,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] CODE_W      = DEF_CODE_W,
    parameter logic [7:0] CODE_S      = DEF_CODE_S,
    parameter logic [7:0] CODE_O      = DEF_CODE_O,
    parameter logic [7:0] CODE_L      = DEF_CODE_L
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       w_out,
    output logic       s_out,
    output logic       o_out,
    output logic       l_out,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_err;

    logic       r_brk;
    logic       r_ext;
    logic       r_w;
    logic       r_s;
    logic       r_o;
    logic       r_l;
    logic [7:0] r_code;
    logic       r_code_valid;
    logic       r_frame_err;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .i_clk        (iVGA_CLK),
        .i_rst_n      (iRST_n),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_dat    (ps2_dat),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_err        (w_err)
    );

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
            r_w          <= 1'b0;
            r_s          <= 1'b0;
            r_o          <= 1'b0;
            r_l          <= 1'b0;
            r_code       <= 8'h00;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= w_byte_valid;
            r_frame_err  <= w_err;
            if (w_err) begin
                // A damaged frame may have been a prefix; never let it qualify the next key.
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_byte_valid) begin
                r_code <= w_byte;
                if (w_byte == PREFIX_BRK) begin
                    r_brk <= 1'b1;
                end else if (w_byte == PREFIX_EXT) begin
                    r_ext <= 1'b1;
                end else begin
                    if (!r_ext) begin
                        if (w_byte == CODE_W) r_w <= ~r_brk;
                        if (w_byte == CODE_S) r_s <= ~r_brk;
                        if (w_byte == CODE_O) r_o <= ~r_brk;
                        if (w_byte == CODE_L) r_l <= ~r_brk;
                    end
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            end
        end
    end

    assign w_out      = r_w;
    assign s_out      = r_s;
    assign o_out      = r_o;
    assign l_out      = r_l;
    assign code       = r_code;
    assign code_valid = r_code_valid;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed Set-2 sequences plus random
// byte streams, compared against a byte-level key-state model.
module tb_ps2_key_decoder;

    localparam int FLT  = 4;
    localparam int TOUT = 600;
    localparam int HALF = 40;

    logic       iVGA_CLK = 1'b0;
    logic       iRST_n   = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_dat  = 1'b1;
    logic       w_out, s_out, o_out, l_out;
    logic [7:0] code;
    logic       code_valid, frame_err;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_err    = 0;

    logic [7:0] m_code  = 8'h00;
    bit         m_brk   = 1'b0;
    bit         m_ext   = 1'b0;
    logic [3:0] m_keys  = 4'b0000;   // {W,S,O,L}
    int         m_valid = 0;
    int         m_err   = 0;

    ps2_key_decoder #(
        .FILTER_LEN  (FLT),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .iVGA_CLK   (iVGA_CLK),
        .iRST_n     (iRST_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .w_out      (w_out),
        .s_out      (s_out),
        .o_out      (o_out),
        .l_out      (l_out),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #20 iVGA_CLK = ~iVGA_CLK;

    always @(negedge iVGA_CLK) begin
        if (code_valid) n_valid++;
        if (frame_err)  n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge iVGA_CLK);
        #1;
    endtask

    function automatic int key_slot(input logic [7:0] b);
        case (b)
            8'h1D:   return 3;
            8'h1B:   return 2;
            8'h44:   return 1;
            8'h4B:   return 0;
            default: return -1;
        endcase
    endfunction

    task automatic model_good(input logic [7:0] b);
        int k;
        m_valid++;
        m_code = b;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            k = key_slot(b);
            if (!m_ext && k >= 0) m_keys[k] = !m_brk;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic model_bad();
        m_err++;
        m_brk = 1'b0;
        m_ext = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s.code", tag),  {24'd0, code}, {24'd0, m_code});
        chk($sformatf("%s.keys", tag),  {28'd0, w_out, s_out, o_out, l_out}, {28'd0, m_keys});
        chk($sformatf("%s.nvalid", tag), n_valid, m_valid);
        chk($sformatf("%s.nerr", tag),   n_err, m_err);
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        ps2_dat = 1'b1;
        if (bad_par || bad_stop) model_bad();
        else model_good(b);
        wait_cyc(30);
        check_all(tag);
    endtask

    logic [7:0] pick [8];

    initial begin
        // Reset held while the keyboard clock toggles
        ps2_dat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ps2_clk = ~ps2_clk;
            wait_cyc(10);
        end
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        check_all("reset_held");
        iRST_n = 1'b1;
        wait_cyc(20);
        check_all("reset_rel");

        send_frame(8'h1D, 0, 0, "make_w");

        send_frame(8'h4B, 0, 0, "make_l");
        send_frame(8'hF0, 0, 0, "brk_pfx");
        send_frame(8'h1D, 0, 0, "break_w");
        chk("l_held", {31'd0, l_out}, 32'd1);

        send_frame(8'hF0, 0, 0, "brk_l_pfx");
        send_frame(8'h4B, 0, 0, "break_l");
        send_frame(8'hE0, 0, 0, "ext1_pfx");
        send_frame(8'h4B, 0, 0, "ext1_4b");
        send_frame(8'hE0, 0, 0, "ext2_pfx");
        send_frame(8'hF0, 0, 0, "ext2_brk");
        send_frame(8'h4B, 0, 0, "ext2_4b");
        send_frame(8'h4B, 0, 0, "plain_l");

        send_frame(8'h44, 1, 0, "bad_par");
        send_frame(8'h44, 0, 1, "bad_stop");
        send_frame(8'h44, 0, 0, "make_o");

        // Partial frame abandoned by the keyboard
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(TOUT + 200);
        model_bad();
        check_all("timeout");

        // Short clock glitches with data low must not start a frame
        ps2_dat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2_clk = 1'b0;
            wait_cyc(FLT - 1);
            ps2_clk = 1'b1;
            wait_cyc(12);
        end
        ps2_dat = 1'b1;
        wait_cyc(20);
        check_all("glitch");
        send_frame(8'h1B, 0, 0, "make_s");

        pick[0] = 8'h1D; pick[1] = 8'h1B; pick[2] = 8'h44; pick[3] = 8'h4B;
        pick[4] = 8'hF0; pick[5] = 8'hE0; pick[6] = 8'hF0; pick[7] = 8'h00;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            int         e;
            b = pick[$urandom_range(0, 7)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            e = $urandom_range(0, 9);
            send_frame(b, e == 0, e == 1, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a frame drops everything
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        iRST_n = 1'b0;
        wait_cyc(5);
        m_keys = 4'b0000;
        m_code = 8'h00;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        check_all("mid_reset");
        ps2_dat = 1'b1;
        iRST_n  = 1'b1;
        wait_cyc(20);
        send_frame(8'h1D, 0, 0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- PS/2 keyboard receiver and scan-code decoder that produces the held-key levels for the Pong game logic: W/S for the left paddle, O/L for the right paddle.
- Its outputs connect directly to the w_in/s_in/o_in/l_in inputs of vga_controller.
- Decodes Set-2 make/break sequences, including the E0 and F0 prefixes.

Parameters:
- FILTER_LEN, 4: consecutive equal synchronized samples required before the filtered ps2_clk changes (range 2..15).
- TIMEOUT_CYC, 50000: idle clock cycles mid-frame before abort (2 ms at 25 MHz); counter is 16 bits.
- CODE_W, 8'h1D: scan code for W.
- CODE_S, 8'h1B: scan code for S.
- CODE_O, 8'h44: scan code for O.
- CODE_L, 8'h4B: scan code for L.

Ports:
- iVGA_CLK, input, 1: system clock, 25 MHz. Clock of the single clock domain.
- iRST_n, input, 1: asynchronous, active-low reset.
- ps2_clk, input, 1: raw PS/2 clock from the keyboard. Asynchronous to iVGA_CLK.
- ps2_dat, input, 1: raw PS/2 data. Asynchronous to iVGA_CLK.
- w_out, output, 1: W key held.
- s_out, output, 1: S key held.
- o_out, output, 1: O key held.
- l_out, output, 1: L key held.
- code, output, 8: last correctly received byte.
- code_valid, output, 1: one-cycle pulse when code updates.
- frame_err, output, 1: one-cycle pulse on parity error, stop-bit error or timeout.

Behaviour:
- Reset:
  - All outputs are 0 and code is 8'h00.
  - FSM goes to IDLE; prefix flags are cleared; the shift register is cleared.
  - Synchronizers and the filtered clock reset to 1.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchronizer.
  - Filtered clock: a counter tracks agreement of the synchronized ps2_clk with the filtered value. When FILTER_LEN consecutive differing samples are seen, the filtered value flips and the counter clears.
  - fall = one-cycle pulse on a filtered 1->0 transition. All bit sampling uses synchronized ps2_dat on the fall cycle.
- Frame format: 11 bits. Start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- FSM states:
  - IDLE: on fall with dat=0, go to DATA and set bit count to 0. On fall with dat=1, stay in IDLE with no error.
  - DATA: on each fall, shift dat into bit 7 of the shift register and increment the count. After the 8th bit, go to PARITY.
  - PARITY: on fall, store dat and go to STOP.
  - STOP: on fall, check the frame and go to IDLE.
    - Check passes when (^data ^ parity)==1 and dat==1.
    - On pass, the following cycle has code=data and code_valid=1.
    - On fail, the following cycle has frame_err=1, code is unchanged, and both prefix flags are cleared.
- Timeout:
  - In DATA, PARITY or STOP, the idle counter increments every cycle without fall and clears on fall.
  - On reaching TIMEOUT_CYC, go to IDLE and pulse frame_err next cycle. Prefix flags are cleared. The counter is held at 0 in IDLE.
- Decode, in the same cycle as code_valid, using the new byte:
  - 8'hF0: set brk.
  - 8'hE0: set ext.
  - Any other byte with ext=1: key outputs are unchanged (extended key); clear brk and ext.
  - Any other byte with ext=0:
    - If the byte matches CODE_x, the matching output becomes ~brk.
    - Clear brk and ext.
  - Repeated make codes (typematic) for a held key keep the output at 1. A break for a key not held keeps it at 0.
- Latency:
  - The stop-bit fall is cycle N. code_valid, code, key outputs and frame_err all register at N+1.
  - End-to-end from the raw ps2_clk edge is N+1 plus 2 synchronizer cycles plus FILTER_LEN cycles.
- Independence:
  - Keys are independent; W and S can both be 1, and their resolution is the consumer's job.
  - Reset mid-frame discards the partial frame and drops all keys.

Decomposition:
- Package ps2_pkg:
  - Set-2 constants: PREFIX_BRK=8'hF0, PREFIX_EXT=8'hE0, default key codes.
  - FSM state encoding: IDLE, DATA, PARITY, STOP (2 bits).
- Sub-module ps2_rx_frame:
  - Contains the synchronizer, filter, FSM and timeout.
  - Outputs byte, byte_valid and err.
- ps2_key_decoder instantiates ps2_rx_frame and holds the prefix and key-state registers.

Test Plan:
1. Reset: hold iRST_n=0 while toggling ps2_clk. Then w_out=s_out=o_out=l_out=0, code=8'h00, and no pulses occur.
2. Make W: send frame 8'h1D with parity 1 at a 20 us bit period. Exactly one code_valid with code=8'h1D; w_out=1; other keys stay 0.
3. Break W and overlap: send 1D, 4B, then F0 1D. w_out goes 1 then 0 and l_out stays 1; there are 4 code_valid pulses, with the last code=8'h1D.
4. Extended ignored: send E0 4B, then E0 F0 4B. l_out stays 0 throughout, and brk/ext are cleared after each sequence; verify a following plain 4B sets l_out=1.
5. Errors:
   - Send 8'h44 with parity 0: one frame_err, no code_valid, o_out=0.
   - Send 8'h44 with stop bit 0: one frame_err.
   - Send a valid 44: o_out=1.
6. Timeout and glitch:
   - Send start bit plus 3 data bits, then idle for more than TIMEOUT_CYC cycles: one frame_err.
   - Inject ps2_clk low pulses of FILTER_LEN-1 cycles: no bits are shifted.
   - Then send valid 1B: s_out=1 and code=8'h1B.
